// File: rtl/pht_update_queue.sv
`default_nettype none
// ============================================================================
// Module   : pht_update_queue
// Purpose  : Queues resolved-branch PHT counter updates and retires one per
//            cycle into the banked PHT. Retirement is skipped while the head's
//            bank collides with a fetch-stage PHT read. After STARVE_LIMIT
//            consecutive blocked cycles, the head is written anyway and fetch
//            is told to discard its read results for that cycle.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            upd_valid/index/prev/taken - update request from branch resolve
//            rd_valid, rd_index  - fetch read ports (rd_index flattened,
//                                  port i at [i*INDEX_WIDTH +: INDEX_WIDTH])
//            pht_we/wa/wv        - PHT write port
//            rd_kill             - fetch must drop this cycle's PHT reads
//            count, full, empty  - occupancy
//            dropped             - update rejected because queue is full
// Revision : 1.0 - initial release
// ============================================================================
module pht_update_queue #(
    parameter int QUEUE_SIZE              = 32,
    parameter int PHT_ENTRY_NUM_BIT_WIDTH = 10,
    parameter int INDEX_WIDTH             = PHT_ENTRY_NUM_BIT_WIDTH,
    parameter int FETCH_WIDTH             = 4,
    parameter int INT_ISSUE_WIDTH         = 2,
    parameter int READ_PORTS              = FETCH_WIDTH,
    parameter int BANK_BIT_WIDTH          = $clog2((FETCH_WIDTH > INT_ISSUE_WIDTH) ?
                                                   FETCH_WIDTH : INT_ISSUE_WIDTH),
    parameter int STARVE_LIMIT            = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              upd_valid,
    input  logic [INDEX_WIDTH-1:0]            upd_index,
    input  logic [1:0]                        upd_prev,
    input  logic                              upd_taken,
    input  logic [READ_PORTS-1:0]             rd_valid,
    input  logic [READ_PORTS*INDEX_WIDTH-1:0] rd_index,
    output logic                              pht_we,
    output logic [INDEX_WIDTH-1:0]            pht_wa,
    output logic [1:0]                        pht_wv,
    output logic                              rd_kill,
    output logic [$clog2(QUEUE_SIZE):0]       count,
    output logic                              full,
    output logic                              empty,
    output logic                              dropped
);

    localparam int PW = $clog2(QUEUE_SIZE);
    localparam int CW = PW + 1;
    localparam int EW = INDEX_WIDTH + 2;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [0:0] NORMAL = 1'b0;
    localparam logic [0:0] FORCE  = 1'b1;

    // Entry layout: {index, value}
    logic [EW-1:0] mem [QUEUE_SIZE];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [0:0]    state;
    logic [0:0]    state_next;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_next;

    logic [1:0]    new_val;
    logic [EW-1:0] head_entry;
    logic          conflict;
    logic          do_write;
    logic          push_ok;

    // 2-bit saturating counter update; never wraps.
    always_comb begin
        new_val = upd_prev;
        if (upd_taken) begin
            if (upd_prev != 2'd3) new_val = upd_prev + 2'd1;
        end else begin
            if (upd_prev != 2'd0) new_val = upd_prev - 2'd1;
        end
    end

    assign head_entry = mem[head];
    assign empty      = (count == '0);
    assign full       = (count == CW'(QUEUE_SIZE));

    // Only the bank-select bits matter for a read/write collision.
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < READ_PORTS; i++) begin
            if (rd_valid[i] &&
                (rd_index[i*INDEX_WIDTH +: BANK_BIT_WIDTH] == head_entry[2 +: BANK_BIT_WIDTH])) begin
                conflict = 1'b1;
            end
        end
    end

    assign do_write = !empty && ((state == FORCE) || !conflict);
    assign pht_we   = do_write;
    assign pht_wa   = do_write ? head_entry[EW-1:2] : '0;
    assign pht_wv   = do_write ? head_entry[1:0]    : 2'd0;
    assign rd_kill  = (state == FORCE);

    // A full queue still accepts a push when the head retires this cycle.
    assign push_ok  = upd_valid && (!full || do_write);
    assign dropped  = upd_valid && full && !do_write;

    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        if (state == FORCE) begin
            state_next  = NORMAL;
            starve_next = '0;
        end else if (empty || do_write) begin
            starve_next = '0;
        end else if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
            // Last tolerated blocked cycle: next cycle writes regardless.
            state_next  = FORCE;
            starve_next = '0;
        end else begin
            starve_next = starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            state      <= NORMAL;
            starve_cnt <= '0;
        end else begin
            if (push_ok)  tail <= tail + PW'(1);
            if (do_write) head <= head + PW'(1);
            count      <= count + CW'(push_ok) - CW'(do_write);
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[tail] <= {upd_index, new_val};
    end

endmodule
`default_nettype wire
